// File: rtl/roe_ctrl_pkg.sv
// Shared definitions for the R.O.E control unit: ALU codes,
// opcode mnemonics and control-state encoding.
package definitions;

    localparam logic [3:0] ALU_SLB    = 4'h0;
    localparam logic [3:0] ALU_ADD    = 4'h1;
    localparam logic [3:0] ALU_SUB    = 4'h2;
    localparam logic [3:0] ALU_SHIFTL = 4'h3;
    localparam logic [3:0] ALU_SHIFTR = 4'h4;
    localparam logic [3:0] ALU_BNZ    = 4'h5;
    localparam logic [3:0] ALU_SLT    = 4'h6;
    localparam logic [3:0] ALU_XOR    = 4'h7;
    localparam logic [3:0] ALU_AND    = 4'h8;
    localparam logic [3:0] ALU_OR     = 4'h9;
    localparam logic [3:0] ALU_NOP    = 4'hF;

    typedef enum logic [3:0] {
        OP_SLB    = 4'h0,
        OP_ADD    = 4'h1,
        OP_SUB    = 4'h2,
        OP_SHIFTL = 4'h3,
        OP_SHIFTR = 4'h4,
        OP_BNZ    = 4'h5,
        OP_SLT    = 4'h6,
        OP_XOR    = 4'h7,
        OP_AND    = 4'h8,
        OP_OR     = 4'h9,
        OP_LOAD   = 4'hA,
        OP_STORE  = 4'hB,
        OP_HALT   = 4'hF
    } op_mnemonic;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_t;

    // Register-writing ALU opcodes: everything up to OR except BNZ.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= ALU_OR) && (op != ALU_BNZ);
    endfunction

endpackage

// File: rtl/roe_ctrl_pc.sv
// Program counter for the R.O.E core: hold, increment with
// 8-bit wrap, or load an absolute branch target.
module roe_pc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] tgt_i,
    output logic [7:0] pc_o
);

    logic [7:0] pc_q;
    logic [7:0] pc_d;

    // Branch load wins over increment; increment wraps FF -> 00.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = tgt_i;
        end else if (inc_i) begin
            pc_d = pc_q + 8'd1;
        end
    end

    // PC register, cleared to 0 on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= 8'h00;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/roe_ctrl.sv
// R.O.E control unit: fetch/decode/execute/memory FSM and PC.
// ROE_ILLEGAL_TRAP_EN: opcodes C-E halt with illegal=1 (else NOP).
module roe_ctrl
    import definitions::*;
#(
    parameter logic [7:0] BR_TGT0 = 8'h00,
    parameter logic [7:0] BR_TGT1 = 8'h10,
    parameter logic [7:0] BR_TGT2 = 8'h20,
    parameter logic [7:0] BR_TGT3 = 8'h30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [8:0] imem_rdata,
    output logic [3:0] alu_op,
    input  logic       branch_result,
    output logic [2:0] rf_raddr1,
    output logic [2:0] rf_raddr0,
    output logic [2:0] rf_waddr,
    output logic       rf_we,
    output logic       wb_sel,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       halted,
    output logic       illegal
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic [8:0]  ir_q;
    logic [8:0]  ir_d;
    logic [3:0]  op;
    logic        pc_inc;
    logic        pc_load;
    logic [7:0]  br_tgt;
    logic [7:0]  pc;
`ifdef ROE_ILLEGAL_TRAP_EN
    logic        illegal_q;
    logic        illegal_d;
`endif

    assign op        = ir_q[8:5];
    assign rf_raddr1 = ir_q[4:2];
    assign rf_raddr0 = {1'b0, ir_q[1:0]};
    assign rf_waddr  = ir_q[4:2];
    assign imem_addr = pc;
    assign halted    = (state_q == ST_HALT);

    roe_pc u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (pc_inc),
        .load_i (pc_load),
        .tgt_i  (br_tgt),
        .pc_o   (pc)
    );

    // Select the absolute BNZ target from the rb field.
    always_comb begin
        br_tgt = BR_TGT0;
        unique case (ir_q[1:0])
            2'd0: br_tgt = BR_TGT0;
            2'd1: br_tgt = BR_TGT1;
            2'd2: br_tgt = BR_TGT2;
            2'd3: br_tgt = BR_TGT3;
        endcase
    end

    // Next-state and output decode for the control FSM.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        imem_req = 1'b0;
        alu_op   = ALU_NOP;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
`ifdef ROE_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (is_alu_op(op)) begin
                    alu_op = op;
                    rf_we  = 1'b1;
                    pc_inc = 1'b1;
                end else begin
                    unique case (op)
                        OP_BNZ: begin
                            alu_op = ALU_BNZ;
                            if (branch_result) begin
                                pc_load = 1'b1;
                            end else begin
                                pc_inc = 1'b1;
                            end
                        end
                        OP_LOAD, OP_STORE: begin
                            state_d = ST_MEM;
                        end
                        OP_HALT: begin
                            state_d = ST_HALT;
                        end
                        default: begin
`ifdef ROE_ILLEGAL_TRAP_EN
                            illegal_d = 1'b1;
                            state_d   = ST_HALT;
`else
                            pc_inc = 1'b1;
`endif
                        end
                    endcase
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_STORE);
                if (dmem_ack) begin
                    if (op == OP_LOAD) begin
                        rf_we  = 1'b1;
                        wb_sel = 1'b1;
                    end
                    pc_inc  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir_q    <= 9'h000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

`ifdef ROE_ILLEGAL_TRAP_EN
    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_roe_ctrl.sv
// Directed testbench for roe_ctrl.
// Bench-side memories answer on the falling edge.
module tb_roe_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [8:0] imem_rdata;
    logic [3:0] alu_op;
    logic       branch_result;
    logic [2:0] rf_raddr1;
    logic [2:0] rf_raddr0;
    logic [2:0] rf_waddr;
    logic       rf_we;
    logic       wb_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       halted;
    logic       illegal;

    int total;
    int bad;

    logic [8:0] imem [256];
    logic       imem_hold;
    int         dmem_wait;
    int         dcnt;

    roe_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .alu_op        (alu_op),
        .branch_result (branch_result),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr0     (rf_raddr0),
        .rf_waddr      (rf_waddr),
        .rf_we         (rf_we),
        .wb_sel        (wb_sel),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ack      (dmem_ack),
        .halted        (halted),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait instruction memory unless held off.
    always @(negedge clk) begin
        imem_ack   = imem_req && !imem_hold;
        imem_rdata = imem[imem_addr];
    end

    // Data memory acks after dmem_wait extra request cycles.
    always @(negedge clk) begin
        if (dmem_req) begin
            dmem_ack = (dcnt == dmem_wait);
            dcnt     = dcnt + 1;
        end else begin
            dmem_ack = 1'b0;
            dcnt     = 0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input logic [8:0] w);
        for (int i = 0; i < 256; i++) imem[i] = w;
    endtask

    task automatic boot();
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        step();
        total++;
        if (imem_req !== 1'b0 || rf_we !== 1'b0 || wb_sel !== 1'b0 ||
            dmem_req !== 1'b0 || dmem_we !== 1'b0 || halted !== 1'b0 ||
            illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got req=%b we=%b wb=%b dreq=%b dwe=%b h=%b il=%b exp all 0",
                     imem_req, rf_we, wb_sel, dmem_req, dmem_we, halted, illegal);
        end
        total++;
        if (alu_op !== 4'hF || imem_addr !== 8'h00) begin
            bad++;
            $display("FAIL reset_op got alu_op=%h pc=%h exp F/00", alu_op, imem_addr);
        end
    endtask

    task automatic test_add();
        fill(9'h1E0);
        imem[0] = 9'h02D;
        boot();
        total++;
        if (imem_req !== 1'b1 || alu_op !== 4'hF || rf_we !== 1'b0) begin
            bad++;
            $display("FAIL add_c1 got req=%b op=%h we=%b exp 1/F/0", imem_req, alu_op, rf_we);
        end
        step();
        total++;
        if (rf_we !== 1'b0 || rf_waddr !== 3'd3 || rf_raddr0 !== 3'd1 ||
            rf_raddr1 !== 3'd3) begin
            bad++;
            $display("FAIL add_c2 got we=%b wa=%0d r0=%0d r1=%0d exp 0/3/1/3",
                     rf_we, rf_waddr, rf_raddr0, rf_raddr1);
        end
        step();
        total++;
        if (alu_op !== 4'h1 || rf_we !== 1'b1 || wb_sel !== 1'b0) begin
            bad++;
            $display("FAIL add_c3 got op=%h we=%b wb=%b exp 1/1/0", alu_op, rf_we, wb_sel);
        end
        step();
        total++;
        if (imem_addr !== 8'h01 || imem_req !== 1'b1 || rf_we !== 1'b0 ||
            alu_op !== 4'hF) begin
            bad++;
            $display("FAIL add_next got pc=%h req=%b we=%b op=%h exp 01/1/0/F",
                     imem_addr, imem_req, rf_we, alu_op);
        end
    endtask

    task automatic test_bnz();
        for (int t = 0; t < 2; t++) begin
            fill(9'h1E0);
            imem[0] = 9'h0A6;
            branch_result = (t == 0);
            boot();
            step();
            step();
            total++;
            if (alu_op !== 4'h5 || rf_we !== 1'b0) begin
                bad++;
                $display("FAIL bnz_exec t=%0d got op=%h we=%b exp 5/0", t, alu_op, rf_we);
            end
            step();
            total++;
            if (imem_addr !== ((t == 0) ? 8'h20 : 8'h01) || imem_req !== 1'b1) begin
                bad++;
                $display("FAIL bnz_target t=%0d got pc=%h req=%b exp %h/1",
                         t, imem_addr, imem_req, (t == 0) ? 8'h20 : 8'h01);
            end
        end
        branch_result = 1'b0;
    endtask

    task automatic test_load_store();
        int nreq;
        int nwe;
        int nwb;
        int we_cyc;
        int store_seen;
        fill(9'h1E0);
        imem[0] = 9'h149;
        imem[1] = 9'h16D;
        dmem_wait = 3;
        nreq = 0;
        nwe = 0;
        nwb = 0;
        we_cyc = 0;
        boot();
        step();
        step();
        total++;
        if (dmem_req !== 1'b0 || rf_we !== 1'b0) begin
            bad++;
            $display("FAIL ld_exec got dreq=%b we=%b exp 0/0", dmem_req, rf_we);
        end
        for (int c = 4; c <= 8; c++) begin
            step();
            if (dmem_req === 1'b1) nreq++;
            if (dmem_we !== 1'b0) nwb += 100;
            if (rf_we === 1'b1) begin
                nwe++;
                we_cyc = c;
                if (wb_sel === 1'b1) nwb++;
            end
        end
        total++;
        if (nreq != 4) begin
            bad++;
            $display("FAIL ld_req_cycles got %0d exp 4", nreq);
        end
        total++;
        if (nwe != 1 || we_cyc != 7 || nwb != 1) begin
            bad++;
            $display("FAIL ld_wb got pulses=%0d cyc=%0d wbsel=%0d exp 1/7/1", nwe, we_cyc, nwb);
        end
        total++;
        if (imem_addr !== 8'h01 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL ld_next got pc=%h req=%b exp 01/1", imem_addr, imem_req);
        end
        dmem_wait = 0;
        store_seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (dmem_req === 1'b1) begin
                store_seen++;
                total++;
                if (dmem_we !== 1'b1 || rf_we !== 1'b0) begin
                    bad++;
                    $display("FAIL st_mem got dwe=%b we=%b exp 1/0", dmem_we, rf_we);
                end
            end
        end
        total++;
        if (store_seen != 1 || imem_addr !== 8'h02) begin
            bad++;
            $display("FAIL st_done got reqcyc=%0d pc=%h exp 1/02", store_seen, imem_addr);
        end
    endtask

    task automatic test_wrap();
        int i;
        fill(9'h0E5);
        imem[0] = 9'h0A7;
        branch_result = 1'b1;
        boot();
        i = 0;
        while (i < 1000 && !(imem_req === 1'b1 && imem_addr === 8'hFF)) begin
            step();
            i++;
        end
        total++;
        if (i >= 1000) begin
            bad++;
            $display("FAIL wrap_reach got pc=%h exp FF within 1000 cycles", imem_addr);
        end else begin
            step();
            step();
            total++;
            if (alu_op !== 4'h7 || rf_we !== 1'b1) begin
                bad++;
                $display("FAIL wrap_exec got op=%h we=%b exp 7/1", alu_op, rf_we);
            end
            step();
            total++;
            if (imem_addr !== 8'h00 || imem_req !== 1'b1) begin
                bad++;
                $display("FAIL wrap_pc got pc=%h req=%b exp 00/1", imem_addr, imem_req);
            end
        end
        branch_result = 1'b0;
    endtask

    task automatic test_halt();
        int errs;
        fill(9'h1E0);
        boot();
        step();
        step();
        step();
        total++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL halt_enter got h=%b req=%b il=%b exp 1/0/0", halted, imem_req, illegal);
        end
        errs = 0;
        for (int c = 0; c < 6; c++) begin
            start = (c % 2 == 0);
            step();
            if (halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0) errs++;
        end
        start = 1'b0;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL halt_hold got %0d bad cycles exp 0", errs);
        end
    endtask

    task automatic test_reset_in_fetch();
        int errs;
        fill(9'h02D);
        imem_hold = 1'b1;
        boot();
        step();
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            bad++;
            $display("FAIL fwait_req got req=%b pc=%h exp 1/00", imem_req, imem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || rf_we !== 1'b0 || dmem_req !== 1'b0 ||
            halted !== 1'b0 || alu_op !== 4'hF || imem_addr !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got req=%b we=%b dreq=%b h=%b op=%h pc=%h",
                     imem_req, rf_we, dmem_req, halted, alu_op, imem_addr);
        end
        imem_hold = 1'b0;
        step();
        rst_n = 1'b1;
        errs = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (imem_req !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL idle_after_reset got %0d req cycles exp 0", errs);
        end
    endtask

    task automatic test_undef_op();
        fill(9'h1E0);
        imem[0] = 9'h185;
        boot();
        step();
        step();
        total++;
        if (rf_we !== 1'b0 || dmem_req !== 1'b0 || alu_op !== 4'hF) begin
            bad++;
            $display("FAIL undef_exec got we=%b dreq=%b op=%h exp 0/0/F", rf_we, dmem_req, alu_op);
        end
        step();
`ifdef ROE_ILLEGAL_TRAP_EN
        total++;
        if (illegal !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL undef_trap got il=%b h=%b req=%b exp 1/1/0", illegal, halted, imem_req);
        end
`else
        total++;
        if (illegal !== 1'b0 || halted !== 1'b0 || imem_addr !== 8'h01 ||
            imem_req !== 1'b1) begin
            bad++;
            $display("FAIL undef_nop got il=%b h=%b pc=%h req=%b exp 0/0/01/1",
                     illegal, halted, imem_addr, imem_req);
        end
`endif
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        branch_result = 1'b0;
        imem_hold = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 9'h000;
        dmem_ack = 1'b0;
        dmem_wait = 0;
        dcnt = 0;
        fill(9'h1E0);
        test_reset();
        test_add();
        test_bnz();
        test_load_store();
        test_wrap();
        test_halt();
        test_reset_in_fetch();
        test_undef_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
